// File: rtl/ex_div_stage.sv
// Execute-stage control with a radix-2 restoring divider.
// Accepts the ID/EX handshake, stalls EX while a divide iterates, and
// presents the EX->MEM valid once the result is registered.
module ex_div_stage #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid_i,
  input  logic              mem_allowin_i,
  input  logic              excep_flush_i,
  input  logic              div_en_i,
  input  logic              div_signed_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic              ex_allowin_o,
  output logic              ex_to_mem_valid_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o,
  output logic              div_busy_o
);

  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] prem_q;      // partial remainder
  logic [DATA_W-1:0] dvd_q;       // dividend bits shifting out, quotient bits shifting in
  logic [DATA_W-1:0] dsr_q;       // divisor magnitude
  logic              q_neg_q;
  logic              r_neg_q;
  logic [DATA_W-1:0] quotient_q;
  logic [DATA_W-1:0] remainder_q;

  logic              ex_ready_go;
  logic [DATA_W-1:0] src1_mag;
  logic [DATA_W-1:0] src2_mag;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;
  logic              step_ok;
  logic [DATA_W-1:0] prem_d;
  logic [DATA_W-1:0] dvd_d;
  logic [DATA_W-1:0] quot_fin;
  logic [DATA_W-1:0] rem_fin;

  // Handshake toward ID/EX and MEM; purely combinational from inputs and state.
  always_comb begin
    ex_ready_go       = !div_en_i || (state_q == DONE);
    ex_to_mem_valid_o = ex_valid_i && ex_ready_go && !excep_flush_i;
    ex_allowin_o      = !ex_valid_i || (ex_ready_go && mem_allowin_i);
    div_busy_o        = (state_q == RUN);
    quotient_o        = quotient_q;
    remainder_o       = remainder_q;
  end

  // Operand magnitudes and one restoring step of the datapath.
  // The trial subtract is DATA_W+1 bits wide: the shifted remainder can reach
  // bit DATA_W, and bit DATA_W of the difference is then its sign.
  always_comb begin
    src1_mag = (div_signed_i && src1_i[DATA_W-1]) ? ('0 - src1_i) : src1_i;
    src2_mag = (div_signed_i && src2_i[DATA_W-1]) ? ('0 - src2_i) : src2_i;
    shifted  = {prem_q, dvd_q[DATA_W-1]};
    trial    = shifted - {1'b0, dsr_q};
    step_ok  = !trial[DATA_W];
    prem_d   = step_ok ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
    dvd_d    = {dvd_q[DATA_W-2:0], step_ok};
    quot_fin = q_neg_q ? ('0 - dvd_d) : dvd_d;
    rem_fin  = r_neg_q ? ('0 - prem_d) : prem_d;
  end

  // Divider FSM; flush overrides every state, result registers survive flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prem_q      <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else if (excep_flush_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ex_valid_i && div_en_i) begin
            prem_q  <= '0;
            cnt_q   <= '0;
            dvd_q   <= src1_mag;
            dsr_q   <= src2_mag;
            q_neg_q <= div_signed_i && (src1_i[DATA_W-1] ^ src2_i[DATA_W-1]);
            r_neg_q <= div_signed_i && src1_i[DATA_W-1];
            if (src2_i == '0) begin
              quotient_q  <= '1;
              remainder_q <= src1_i;
              state_q     <= DONE;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          prem_q <= prem_d;
          dvd_q  <= dvd_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            quotient_q  <= quot_fin;
            remainder_q <= rem_fin;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (ex_valid_i && mem_allowin_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_stage.sv
// Self-checking bench for ex_div_stage with a plain-arithmetic divide model.
module tb_ex_div_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        mem_allowin;
  logic        flush;
  logic        div_en;
  logic        div_signed;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        ex_allowin;
  logic        ex_to_mem_valid;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_busy;

  int errors;
  int checks;

  ex_div_stage #(.DATA_W(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ex_valid_i        (ex_valid),
    .mem_allowin_i     (mem_allowin),
    .excep_flush_i     (flush),
    .div_en_i          (div_en),
    .div_signed_i      (div_signed),
    .src1_i            (src1),
    .src2_i            (src2),
    .ex_allowin_o      (ex_allowin),
    .ex_to_mem_valid_o (ex_to_mem_valid),
    .quotient_o        (quotient),
    .remainder_o       (remainder),
    .div_busy_o        (div_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: truncating division, remainder takes the dividend's sign.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  input logic sgn,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endfunction

  // One divide from acceptance to handoff; leaves EX inputs asserted so a
  // following call starts in the IDLE cycle right after the handoff.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input int unsigned hold);
    logic [31:0] eq;
    logic [31:0] er;
    int lat;
    int busy;
    int allow_bad;
    int exp_lat;
    ref_div(a, b, sgn, eq, er);
    exp_lat = (b == 32'd0) ? 1 : 33;
    @(negedge clk);
    ex_valid = 1'b1; div_en = 1'b1; div_signed = sgn; flush = 1'b0;
    src1 = a; src2 = b; mem_allowin = (hold == 0);
    #1;
    lat = 0; busy = 0; allow_bad = 0;
    while (ex_to_mem_valid !== 1'b1 && lat < 40) begin
      if (div_busy === 1'b1) busy++;
      if (ex_allowin !== 1'b0) allow_bad++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL latency a=%h b=%h got=%0d exp=%0d", a, b, lat, exp_lat);
    end
    checks++;
    if (busy !== exp_lat - 1) begin
      errors++; $display("FAIL busy_cycles a=%h b=%h got=%0d exp=%0d", a, b, busy, exp_lat - 1);
    end
    checks++;
    if (allow_bad !== 0) begin
      errors++; $display("FAIL allowin_stall a=%h b=%h got=%0d exp=0", a, b, allow_bad);
    end
    checks++;
    if (quotient !== eq) begin
      errors++; $display("FAIL quotient a=%h b=%h s=%0d got=%h exp=%h", a, b, sgn, quotient, eq);
    end
    checks++;
    if (remainder !== er) begin
      errors++; $display("FAIL remainder a=%h b=%h s=%0d got=%h exp=%h", a, b, sgn, remainder, er);
    end
    for (int i = 0; i < int'(hold); i++) begin
      @(negedge clk);
      checks++;
      if (ex_to_mem_valid !== 1'b1 || ex_allowin !== 1'b0 || quotient !== eq || remainder !== er) begin
        errors++;
        $display("FAIL hold cyc=%0d got=v%0d a%0d q=%h r=%h exp=v1 a0 q=%h r=%h",
                 i, ex_to_mem_valid, ex_allowin, quotient, remainder, eq, er);
      end
    end
    mem_allowin = 1'b1;
    #1;
    checks++;
    if (ex_allowin !== 1'b1) begin
      errors++; $display("FAIL handoff_allowin got=%0d exp=1", ex_allowin);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ex_valid = 1'b0; mem_allowin = 1'b0; flush = 1'b0;
    div_en = 1'b0; div_signed = 1'b0; src1 = '0; src2 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (ex_allowin !== 1'b1 || ex_to_mem_valid !== 1'b0 || div_busy !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got=a%0d v%0d b%0d exp=a1 v0 b0", ex_allowin, ex_to_mem_valid, div_busy);
    end
    checks++;
    if (quotient !== 32'd0 || remainder !== 32'd0) begin
      errors++; $display("FAIL reset_results got=q%h r%h exp=0 0", quotient, remainder);
    end
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    ex_valid = 1'b1; div_en = 1'b0; mem_allowin = 1'b1;
    #1;
    checks++;
    if (ex_to_mem_valid !== 1'b1 || ex_allowin !== 1'b1 || div_busy !== 1'b0) begin
      errors++; $display("FAIL pass_same_cycle got=v%0d a%0d b%0d exp=v1 a1 b0", ex_to_mem_valid, ex_allowin, div_busy);
    end
    @(negedge clk);
    checks++;
    if (div_busy !== 1'b0 || ex_to_mem_valid !== 1'b1) begin
      errors++; $display("FAIL pass_stays_idle got=b%0d v%0d exp=b0 v1", div_busy, ex_to_mem_valid);
    end
    mem_allowin = 1'b0;
    #1;
    checks++;
    if (ex_allowin !== 1'b0 || ex_to_mem_valid !== 1'b1) begin
      errors++; $display("FAIL pass_backpressure got=a%0d v%0d exp=a0 v1", ex_allowin, ex_to_mem_valid);
    end
    ex_valid = 1'b0;
    #1;
    checks++;
    if (ex_allowin !== 1'b1 || ex_to_mem_valid !== 1'b0) begin
      errors++; $display("FAIL empty_ex got=a%0d v%0d exp=a1 v0", ex_allowin, ex_to_mem_valid);
    end
  endtask

  task automatic test_directed();
    do_div(32'd100, 32'd7, 1'b0, 0);
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    do_div(32'd5, 32'd0, 1'b0, 0);
    do_div(32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    do_div(32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 0);
  endtask

  task automatic test_backpressure_flush();
    do_div(32'd9, 32'd3, 1'b0, 5);
    @(negedge clk);
    ex_valid = 1'b1; div_en = 1'b1; div_signed = 1'b0;
    src1 = 32'd1000; src2 = 32'd7; mem_allowin = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (ex_to_mem_valid !== 1'b0 || div_busy !== 1'b1) begin
        errors++; $display("FAIL run_before_flush cyc=%0d got=v%0d b%0d exp=v0 b1", i, ex_to_mem_valid, div_busy);
      end
    end
    flush = 1'b1;
    #1;
    checks++;
    if (ex_to_mem_valid !== 1'b0) begin
      errors++; $display("FAIL flush_run_valid got=%0d exp=0", ex_to_mem_valid);
    end
    @(negedge clk);
    checks++;
    if (div_busy !== 1'b0 || ex_to_mem_valid !== 1'b0) begin
      errors++; $display("FAIL flush_run_idle got=b%0d v%0d exp=b0 v0", div_busy, ex_to_mem_valid);
    end
    checks++;
    if (quotient !== 32'd3 || remainder !== 32'd0) begin
      errors++; $display("FAIL flush_keeps_results got=q%h r%h exp=3 0", quotient, remainder);
    end
    flush = 1'b0; ex_valid = 1'b0;
  endtask

  task automatic test_flush_idle_done();
    @(negedge clk);
    ex_valid = 1'b1; div_en = 1'b1; div_signed = 1'b0;
    src1 = 32'd20; src2 = 32'd4; flush = 1'b1; mem_allowin = 1'b1;
    #1;
    checks++;
    if (ex_to_mem_valid !== 1'b0) begin
      errors++; $display("FAIL flush_idle_valid got=%0d exp=0", ex_to_mem_valid);
    end
    @(negedge clk);
    checks++;
    if (div_busy !== 1'b0) begin
      errors++; $display("FAIL flush_idle_nostart got=%0d exp=0", div_busy);
    end
    flush = 1'b0;
    src1 = 32'd6; src2 = 32'd0; mem_allowin = 1'b0;
    @(negedge clk);
    checks++;
    if (ex_to_mem_valid !== 1'b1) begin
      errors++; $display("FAIL div0_done_t1 got=%0d exp=1", ex_to_mem_valid);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (ex_to_mem_valid !== 1'b0) begin
      errors++; $display("FAIL flush_done_valid got=%0d exp=0", ex_to_mem_valid);
    end
    @(negedge clk);
    flush = 1'b0; ex_valid = 1'b0;
    #1;
    checks++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd6 || div_busy !== 1'b0) begin
      errors++; $display("FAIL flush_done_after got=q%h r%h b%0d exp=ffffffff 6 0", quotient, remainder, div_busy);
    end
    ex_valid = 1'b1;
    #1;
    checks++;
    if (ex_to_mem_valid !== 1'b0) begin
      errors++; $display("FAIL flush_done_idle got=%0d exp=0", ex_to_mem_valid);
    end
    ex_valid = 1'b0; mem_allowin = 1'b1;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    ex_valid = 1'b1; div_en = 1'b1; div_signed = 1'b0;
    src1 = 32'd1000; src2 = 32'd3; mem_allowin = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (div_busy !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0) begin
      errors++; $display("FAIL async_reset got=b%0d q%h r%h exp=0 0 0", div_busy, quotient, remainder);
    end
    ex_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_div(32'd12, 32'd4, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    do_div(32'd77, 32'd11, 1'b0, 0);
    do_div(32'hFFFF_FF9C, 32'd9, 1'b1, 0);
    do_div(32'd3, 32'd0, 1'b1, 0);
    do_div(32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(2, 15));
        4: b = a;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      do_div(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_passthrough();
    test_directed();
    test_backpressure_flush();
    test_flush_idle_done();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
